uart_transmitter: RTL and testbench
===================================

Name: uart_transmitter

Overview:
Serialises bytes into 8N1 UART frames on a single TX line: start bit, 8 data bits LSB first, one stop bit. It is the transmit-side counterpart of uart_receiver and shares its bit timing, so the two can be looped back directly. A one-entry holding register lets the producer hand over the next byte while the current frame shifts out, so consecutive frames go out with no idle gap.

Parameters:
CLKS_PER_BIT, 104, clock cycles per bit period (1 MHz clk gives about 9600 baud); must be >= 2
DATA_BITS, 8, data bits per frame

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-low reset (rst==0 at a rising edge resets the block)
in_data  input  DATA_BITS  byte to send, sampled on accept
in_valid  input  1  producer has a byte; must hold in_data stable until accepted
in_ready  output  1  block can accept a byte this cycle (registered, equals ~hold_full)
tx  output  1  serial line, idle high (registered)
busy  output  1  a frame is in progress (state != IDLE)
done  output  1  one-cycle pulse in the last cycle of each stop bit

Behaviour:
- Reset: tx=1, in_ready=1, busy=0, done=0, state=IDLE, hold_full=0, bit counter and clock counter =0. Reset mid-frame aborts the frame: tx=1 on the next edge, the held byte is discarded, no done pulse.
- Accept: occurs at a rising edge where in_valid && in_ready. If in_valid is high while in_ready is low, the edge is ignored and no state changes.
- States and transitions:
  - IDLE: tx=1. On accept, load the shift register from in_data and go to START. tx=0 in the first cycle after the accept edge, so latency is 1 clock.
  - START: tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, shifting right between bits. After DATA_BITS bits, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles; done=1 in the final cycle. At the end of STOP:
    - if hold_full: load the shift register from the hold register, clear hold_full, go to START (no idle gap);
    - else if accept occurs in that same cycle: bypass, load from in_data, go to START;
    - else go to IDLE.
- Hold register: an accept while state != IDLE, and not the STOP-end bypass case, writes the hold register and sets hold_full. in_ready falls on the next edge.
- Frame length: exactly (DATA_BITS+2)*CLKS_PER_BIT cycles of tx from the first start-bit cycle to the last stop-bit cycle.
- Clock counter: width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1, wraps to 0 on each bit boundary.
- Bit index: width $clog2(DATA_BITS+1).
- busy falls in the first IDLE cycle.

Decomposition:
- Package uart_pkg holds:
  - the state enum IDLE/START/DATA/STOP (2 bits);
  - default constants UART_CLKS_PER_BIT=104 and UART_DATA_BITS=8, which uart_receiver also uses.
- One natural sub-module, uart_baud_gen: a clock counter with a restart input and a one-cycle bit_end pulse when count==CLKS_PER_BIT-1. The FSM, shift register and hold register stay in uart_transmitter.

Test Plan:
- Reset: hold rst=0 for 2 cycles with in_valid=1 -> tx=1, busy=0, in_ready=1, done=0, nothing accepted. Release rst; tx stays 1 while in_valid=0.
- Single byte: CLKS_PER_BIT=104, accept in_data=8'h65 -> tx low 104 cycles starting 1 cycle after accept. Data bits 1,0,1,0,0,1,1,0, each 104 cycles. Stop high 104 cycles, done pulse in cycle 1040 of the frame, then busy=0.
- Back-to-back: accept 8'h65, then 8'hCF during its DATA phase -> in_ready=0 after the second accept. The first stop bit is followed immediately by the second start bit (no idle cycle). Second-frame data bits 1,1,1,1,0,0,1,1. in_ready=1 again from the first cycle of the second START. Exactly 2 done pulses, 1040 cycles apart.
- Backpressure: with hold_full, hold in_valid=1 and in_data=8'hA5 -> not accepted until in_ready=1. 8'hA5 is then sent exactly once, after the held byte.
- Loopback: connect tx to uart_receiver dataValue (same clk, 104 clocks/bit), send 8'h65 then 8'hCF -> receiver data equals 8'h65, then 8'hCF.
- Reset mid-frame: assert rst=0 during DATA bit 3 with a byte held -> tx=1 next edge, busy=0, hold discarded, no done pulse. A subsequent 8'h3C is sent correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states and default bit timing,
// common to uart_transmitter and uart_receiver.
package uart_pkg;

  localparam int unsigned UART_CLKS_PER_BIT = 104;
  localparam int unsigned UART_DATA_BITS    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each bit period. Held at zero while restart is high.
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  output logic [CNT_W-1:0] count,
  output logic             bit_end_c
);

  assign bit_end_c = (count == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (!rst || restart) begin
      count <= '0;
    end else if (bit_end_c) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a one-entry holding register so consecutive
// frames leave back to back with no idle gap.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);

  uart_state_e          state;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] hold;
  logic                 hold_full;
  logic [BIT_W-1:0]     bit_idx;
  logic [CNT_W-1:0]     count;
  logic                 bit_end_c;
  logic                 accept_c;
  logic                 stop_end_c;

  assign accept_c   = in_valid && in_ready;
  assign stop_end_c = (state == STOP) && bit_end_c;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .restart  (state == IDLE),
    .count    (count),
    .bit_end_c(bit_end_c)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      tx        <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      in_ready  <= 1'b1;
      hold_full <= 1'b0;
      bit_idx   <= '0;
      shift     <= '0;
      hold      <= '0;
    end else begin
      // done is set one cycle early so it lands in the final stop-bit cycle
      done <= (state == STOP) && (count == CNT_W'(CLKS_PER_BIT - 2));

      case (state)
        IDLE: begin
          if (accept_c) begin
            shift <= in_data;
            state <= START;
            tx    <= 1'b0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (bit_end_c) begin
            state   <= DATA;
            tx      <= shift[0];
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (bit_end_c) begin
            if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_idx <= bit_idx + BIT_W'(1);
            end
          end
        end
        STOP: begin
          if (bit_end_c) begin
            if (hold_full) begin
              shift     <= hold;
              hold_full <= 1'b0;
              in_ready  <= 1'b1;
              state     <= START;
              tx        <= 1'b0;
            end else if (accept_c) begin
              shift <= in_data;
              state <= START;
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase

      // Mid-frame accept parks the byte in the holding register
      if (accept_c && (state != IDLE) && !stop_end_c) begin
        hold      <= in_data;
        hold_full <= 1'b1;
        in_ready  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: per-cycle frame checks against
// hand-written bit patterns plus a mid-bit sampling line decoder.
module tb_uart_transmitter;

  localparam int CPB   = 104;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_t[$];

  int         rx_cnt;
  int         rx_k;
  bit         rx_on = 1'b0;
  logic [7:0] rx_sh;
  logic [7:0] rx_q[$];

  int lows;
  int ndone;

  uart_transmitter #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .tx      (tx),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (done === 1'b1) done_t.push_back(cyc);

  // Line decoder: detect start, sample each bit at its centre
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (tx === 1'b0) begin
        rx_on  = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % CPB == CPB / 2) begin
        rx_k = rx_cnt / CPB;
        if (rx_k == 0) begin
          if (tx !== 1'b0) rx_on = 1'b0;
        end else if (rx_k <= 8) begin
          rx_sh[rx_k-1] = tx;
        end else begin
          if (tx === 1'b1) rx_q.push_back(rx_sh);
          rx_on = 1'b0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a byte while idle; returns in the first start-bit cycle
  task automatic start_idle(input string tag, input logic [7:0] b);
    check({tag, "_ready_idle"}, 32'(in_ready), 32'd1);
    check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    in_data  = b;
    in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
  endtask

  // Check one whole frame cycle by cycle; optionally drive in_valid/in_data
  task automatic run_frame(input string tag, input logic [9:0] fr,
                           input int s1_at, input logic [7:0] s1_d,
                           input int s2_at, input logic [7:0] s2_d,
                           input int clr_at);
    logic rdy;
    rdy = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      check({tag, "_tx"}, 32'(tx), 32'(fr[i/CPB]));
      check({tag, "_done"}, 32'(done), 32'(i == FRAME - 1));
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_ready"}, 32'(in_ready), 32'(rdy));
      if (i == s1_at) begin
        in_valid = 1'b1;
        in_data  = s1_d;
      end
      if (i == s2_at) begin
        in_valid = 1'b1;
        in_data  = s2_d;
      end
      if (i == clr_at) in_valid = 1'b0;
      if (in_valid && rdy && i != FRAME - 1) rdy = 1'b0;
      tick(1);
    end
  endtask

  initial begin
    rst      = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hFF;

    // Reset with a byte on offer: nothing must be taken
    tick(2);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    rst      = 1'b1;
    in_valid = 1'b0;
    tick(3);
    check("post_rst_tx", 32'(tx), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);

    // Single byte 0x65
    start_idle("s65", 8'h65);
    run_frame("s65", 10'b1_0110_0101_0, -1, 8'h00, -1, 8'h00, -1);
    check("s65_idle_busy", 32'(busy), 32'd0);
    check("s65_idle_tx", 32'(tx), 32'd1);
    check("s65_rx_n", 32'(rx_q.size()), 32'd1);
    check("s65_rx_b", 32'(rx_q[0]), 32'h65);
    tick(5);

    // 0x65, 0xCF queued mid-frame, then 0xA5 held off by backpressure
    start_idle("b1", 8'h65);
    run_frame("b1", 10'b1_0110_0101_0, 300, 8'hCF, 301, 8'hA5, -1);
    run_frame("b2", 10'b1_1100_1111_0, -1, 8'h00, -1, 8'h00, 1);
    run_frame("b3", 10'b1_1010_0101_0, -1, 8'h00, -1, 8'h00, -1);
    check("b_idle_busy", 32'(busy), 32'd0);
    check("b_idle_tx", 32'(tx), 32'd1);
    check("b_idle_ready", 32'(in_ready), 32'd1);
    check("b_rx_n", 32'(rx_q.size()), 32'd4);
    check("b_rx_1", 32'(rx_q[1]), 32'h65);
    check("b_rx_2", 32'(rx_q[2]), 32'hCF);
    check("b_rx_3", 32'(rx_q[3]), 32'hA5);
    check("b_done_n", 32'(done_t.size()), 32'd4);
    check("b_done_gap12", 32'(done_t[2] - done_t[1]), 32'd1040);
    check("b_done_gap23", 32'(done_t[3] - done_t[2]), 32'd1040);
    tick(5);

    // Reset during data bit 3 with a byte held
    start_idle("r", 8'h11);
    tick(200);
    in_data  = 8'h77;
    in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
    check("r_ready_held", 32'(in_ready), 32'd0);
    tick(249);
    check("r_busy_mid", 32'(busy), 32'd1);
    ndone = done_t.size();
    rst = 1'b0;
    tick(1);
    check("r_tx", 32'(tx), 32'd1);
    check("r_busy", 32'(busy), 32'd0);
    check("r_ready", 32'(in_ready), 32'd1);
    check("r_done", 32'(done), 32'd0);
    rst  = 1'b1;
    lows = 0;
    for (int i = 0; i < 1200; i++) begin
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
      tick(1);
    end
    check("r_quiet_line", 32'(lows), 32'd0);
    check("r_no_done", 32'(done_t.size()), 32'(ndone));
    check("r_rx_n", 32'(rx_q.size()), 32'd4);

    // Normal traffic after the aborted frame
    start_idle("s3c", 8'h3C);
    run_frame("s3c", 10'b1_0011_1100_0, -1, 8'h00, -1, 8'h00, -1);
    check("s3c_idle_busy", 32'(busy), 32'd0);
    check("s3c_rx_n", 32'(rx_q.size()), 32'd5);
    check("s3c_rx_b", 32'(rx_q[4]), 32'h3C);
    check("s3c_done_n", 32'(done_t.size()), 32'(ndone + 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
